mem_arbiter: RTL

Memory-side responder for the single-cycle/pipelined datapath's instruction and data request lines. It accepts instruction-fetch and data read/write requests, serialises them onto one shared RAM port, and returns single-cycle `i_hit`/`d_hit` pulses with load data. Each request line is held high until its hit is seen and is dropped the following cycle. The block sits between the datapath's request logic and the RAM model/bus, with data accesses taking priority over fetches.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter: serialises data and fetch requests onto one RAM
// port with data priority, returning one-cycle hit pulses with load data.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_store,
    output logic              i_hit,
    output logic [DATA_W-1:0] i_load,
    output logic              d_hit,
    output logic [DATA_W-1:0] d_load,
    output logic              ram_ren,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_store,
    input  logic [DATA_W-1:0] ram_load,
    input  logic              ram_ready,
    output logic              err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] OP_IFETCH = 2'd0;
    localparam logic [1:0] OP_DREAD  = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [1:0]        op;
    logic [7:0]        wait_cnt;
    logic [1:0]        grant_op;
    logic              grant_valid;
    logic              finish;
    logic [DATA_W-1:0] resp;

    always_comb begin
        grant_op    = OP_IFETCH;
        grant_valid = 1'b1;
        priority case (1'b1)
            d_wen:   grant_op = OP_WRITE;
            d_ren:   grant_op = OP_DREAD;
            i_ren:   grant_op = OP_IFETCH;
            default: grant_valid = 1'b0;
        endcase
    end

    // A timeout completes the access with a zero response.
    assign finish = ram_ready || (wait_cnt == LAST_WAIT);
    assign resp   = (ram_ready && op != OP_WRITE) ? ram_load : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            op        <= OP_IFETCH;
            wait_cnt  <= '0;
            i_hit     <= 1'b0;
            d_hit     <= 1'b0;
            i_load    <= '0;
            d_load    <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        op        <= grant_op;
                        ram_addr  <= (grant_op == OP_IFETCH) ? i_addr : d_addr;
                        ram_store <= (grant_op == OP_WRITE) ? d_store : '0;
                        ram_ren   <= (grant_op != OP_WRITE);
                        ram_wen   <= (grant_op == OP_WRITE);
                        wait_cnt  <= '0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        ram_ren <= 1'b0;
                        ram_wen <= 1'b0;
                        i_hit   <= (op == OP_IFETCH);
                        d_hit   <= (op != OP_IFETCH);
                        i_load  <= (op == OP_IFETCH) ? resp : '0;
                        d_load  <= (op == OP_DREAD) ? resp : '0;
                        if (!ram_ready) begin
                            err <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    i_hit  <= 1'b0;
                    d_hit  <= 1'b0;
                    i_load <= '0;
                    d_load <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
